// File: rtl/lif_tdm_scheduler.sv
// rtl/lif_tdm_scheduler.sv - time-multiplexed LIF neuron sweep scheduler, optional LIF_REFRACTORY_EN
// One shared leak/integrate/fire datapath walks N_NEURONS membranes once per i_start.
`ifndef DATA_LENGTH
`define DATA_LENGTH 32
`endif

module lif_tdm_scheduler #(
    parameter int N_NEURONS = 16,
    parameter int IDX_W     = 4,
    parameter int REST      = 700000,
    parameter int THRESH    = 2147483647,
    parameter int DECAY     = 40000
`ifdef LIF_REFRACTORY_EN
    ,
    parameter int REFRAC    = 2
`endif
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_cur_valid,
    input  logic [`DATA_LENGTH-1:0] i_cur_data,
    output logic                    o_cur_ready,
    output logic [IDX_W-1:0]        o_cur_idx,
    output logic                    o_spike_valid,
    output logic [IDX_W-1:0]        o_spike_id,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [15:0]             o_timestep
);
    localparam int DW = `DATA_LENGTH;
    localparam logic [DW-1:0] REST_V   = DW'(REST);
    localparam logic [DW-1:0] THRESH_V = DW'(THRESH);
    localparam logic [DW-1:0] DECAY_V  = DW'(DECAY);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [15:0]      ts_q;
    logic             spike_valid_q;
    logic [IDX_W-1:0] spike_id_q;
    logic [DW-1:0]    mem_q [N_NEURONS];

    logic             run;
    logic             accept;
    logic             last;
    logic             fire;
    logic             refr;
    logic [DW-1:0]    v;
    logic [DW-1:0]    mem_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_RUN;
            S_RUN:   if (accept && last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run    = (state_q == S_RUN);
        o_busy = (state_q != S_IDLE);
        o_done = (state_q == S_DONE);
    end

    assign o_cur_ready   = run;
    assign accept        = run & i_cur_valid;
    assign last          = (idx_q == IDX_W'(N_NEURONS - 1));
    assign o_cur_idx     = idx_q;
    assign o_timestep    = ts_q;
    assign o_spike_valid = spike_valid_q;
    assign o_spike_id    = spike_id_q;
    assign v             = mem_q[idx_q];

    // Wrapping arithmetic: sums above 2^DW roll over rather than clamp.
    always_comb begin
        fire    = 1'b0;
        mem_nxt = v - DECAY_V + i_cur_data;
        if (refr) begin
            mem_nxt = REST_V;
        end else if (v >= THRESH_V) begin
            mem_nxt = REST_V;
            fire    = 1'b1;
        end else if (v < REST_V) begin
            mem_nxt = REST_V + i_cur_data;
        end
    end

`ifdef LIF_REFRACTORY_EN
    logic [1:0] refrac_q [N_NEURONS];

    assign refr = (refrac_q[idx_q] != 2'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_NEURONS; i++) refrac_q[i] <= 2'd0;
        end else if (accept) begin
            if (refr) begin
                refrac_q[idx_q] <= refrac_q[idx_q] - 2'd1;
            end else if (fire) begin
                refrac_q[idx_q] <= 2'(REFRAC);
            end
        end
    end
`else
    assign refr = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_NEURONS; i++) mem_q[i] <= '0;
        end else if (accept) begin
            mem_q[idx_q] <= mem_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_q         <= '0;
            ts_q          <= '0;
            spike_valid_q <= 1'b0;
            spike_id_q    <= '0;
        end else begin
            spike_valid_q <= accept & fire;
            if (accept && fire) spike_id_q <= idx_q;
            if (state_q == S_IDLE && i_start) begin
                idx_q <= '0;
            end else if (accept) begin
                idx_q <= idx_q + 1'b1;
            end
            if (accept && last) ts_q <= ts_q + 16'd1;
        end
    end
endmodule

// File: doc/lif_tdm_scheduler.md
LIF_TDM_SCHEDULER -- requirements
Module: lif_tdm_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 16: number of time-multiplexed virtual neurons (power of two, 2..256).
REQ-002 SHALL have parameter IDX_W, default 4: log2(N_NEURONS).
REQ-003 SHALL have parameter REST, default 700000: resting voltage.
REQ-004 SHALL have parameter THRESH, default 2147483647: firing threshold.
REQ-005 SHALL have parameter DECAY, default 40000: linear leak per timestep.
REQ-006 SHALL have port i_clk, input, 1: clock, rising edge.
REQ-007 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port i_start, input, 1: single-cycle pulse that starts one timestep sweep.
REQ-009 SHALL have port i_cur_valid, input, 1: input current valid.
REQ-010 SHALL have port i_cur_data, input, `DATA_LENGTH: synaptic current for the neuron at o_cur_idx.
REQ-011 SHALL have port o_cur_ready, output, 1: scheduler accepts current.
REQ-012 SHALL have port o_cur_idx, output, IDX_W: neuron index the current is consumed for.
REQ-013 SHALL have port o_spike_valid, output, 1: one-cycle spike event.
REQ-014 SHALL have port o_spike_id, output, IDX_W: index of the firing neuron.
REQ-015 SHALL have port o_busy, output, 1: sweep in progress.
REQ-016 SHALL have port o_done, output, 1: one-cycle pulse at sweep end.
REQ-017 SHALL have port o_timestep, output, 16: count of completed sweeps, wrapping.

Function
REQ-018 SHALL hold N_NEURONS membrane registers of `DATA_LENGTH bits, unsigned, updated through one shared LIF datapath.
REQ-019 SHALL implement FSM states IDLE, RUN and DONE; IDLE->RUN on i_start, RUN->DONE on acceptance for index N_NEURONS-1, DONE->IDLE after one cycle.
REQ-020 SHALL ignore i_start in RUN and DONE, with no queuing.
REQ-021 SHALL drive o_cur_ready=1 only in RUN, and o_busy=1 in RUN and DONE.
REQ-022 SHALL reset o_cur_idx to 0 on entry to RUN and increment it by 1 on each accepted transfer (i_cur_valid & o_cur_ready).
REQ-023 SHALL hold index and state while i_cur_valid=0 in RUN; stalls have no time limit.
REQ-024 SHALL update, on the accepting edge, neuron v=mem[idx]: if v>=THRESH, mem<=REST, fire, current discarded; else if v<REST, mem<=REST+cur; else mem<=v-DECAY+cur.
REQ-025 SHALL compute all arithmetic modulo 2^`DATA_LENGTH, with no saturation.
REQ-026 SHALL assert o_spike_valid with o_spike_id=idx in the cycle after the firing transfer, for exactly one cycle, with no backpressure.
REQ-027 SHALL pulse o_done in the DONE state and increment o_timestep on the same edge that enters DONE.
REQ-028 SHALL give a minimum sweep length of N_NEURONS+1 cycles from i_start to o_done, with i_cur_valid held high.

Reset
REQ-029 SHALL, while i_rst=1, clear all membranes to 0, set the FSM to IDLE, and drive o_cur_idx, o_timestep, o_spike_valid, o_done and o_busy to 0; reset has priority over every other input.
REQ-030 SHALL abort a sweep on reset mid-sweep, with no o_done and no pending spike emitted.

Configuration
REQ-031 SHALL, with macro LIF_REFRACTORY_EN defined, add parameter REFRAC (default 2) and per-neuron 2-bit counters: a neuron firing loads REFRAC; while nonzero, the transfer decrements it and holds mem at REST, discarding current.
REQ-032 SHALL, without LIF_REFRACTORY_EN, omit the counters, and behaviour SHALL be exactly REQ-024.

Verification
REQ-033 SHALL verify: reset, then i_start with cur=0 for all neurons -> all mem=700000, no spikes, o_done at cycle 17, o_timestep=1.
REQ-034 SHALL verify: neuron 3 fed cur=2147000000 in sweep 1 -> mem=2147700000 >= THRESH; sweep 2 -> o_spike_valid with o_spike_id=3, mem[3]=700000.
REQ-035 SHALL verify: mem=800000 with cur=10000 -> 770000 after the sweep.
REQ-036 SHALL verify: i_cur_valid low for 5 cycles at idx 7 -> o_cur_idx stays 7, o_done delayed by exactly 5 cycles; i_start pulses during the sweep are ignored.
REQ-037 SHALL verify: i_rst at idx 9 -> no o_done, all mem=0, o_busy=0 the next cycle; a new i_start begins at idx 0.
REQ-038 SHALL verify, with LIF_REFRACTORY_EN: a neuron that fires at sweep k holds 700000 for sweeps k+1 and k+2 despite cur=5000000, then integrates at sweep k+3.
